// File: rtl/w0rm_bus_pkg.sv
// w0rm_bus_pkg: FSM encoding and sizing helpers shared by the w0rm bus arbiter files
package w0rm_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } bus_state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Wide enough to hold TIMEOUT_CYCLES-1, the last WAIT count before giving up
    function automatic int cnt_width(input int t);
        return (t > 1) ? $clog2(t) : 1;
    endfunction

endpackage

// File: rtl/w0rm_rr_arbiter.sv
// w0rm_rr_arbiter: picks the first requester after the previous winner, wrapping around
module w0rm_rr_arbiter
    import w0rm_bus_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int IW        = idx_width(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [IW-1:0]        last_i,
    output logic [NUM_PORTS-1:0] grant_o,
    output logic [IW-1:0]        idx_o
);

    logic          found;
    logic [IW-1:0] cand;

    always_comb begin
        found = 1'b0;
        cand  = '0;
        idx_o = '0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            cand = IW'((int'(last_i) + i) % NUM_PORTS);
            if (!found && req_i[cand]) begin
                found = 1'b1;
                idx_o = cand;
            end
        end
    end

    assign grant_o = found ? (NUM_PORTS'(1) << idx_o) : '0;

endmodule

// File: rtl/w0rm_core_bus_arbiter.sv
// w0rm_core_bus_arbiter: round-robin funnel of NUM_PORTS request ports onto one external bus,
// one transaction outstanding, with a WAIT timeout that answers with an error.
module w0rm_core_bus_arbiter
    import w0rm_bus_pkg::*;
#(
    parameter int NUM_PORTS      = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_PORTS-1:0]             req_valid,
    input  logic [NUM_PORTS-1:0]             req_read,
    input  logic [NUM_PORTS-1:0]             req_write,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_data,
    output logic [NUM_PORTS-1:0]             req_ready,
    output logic [NUM_PORTS-1:0]             resp_valid,
    output logic                             resp_error,
    output logic [DATA_WIDTH-1:0]            resp_data,
    output logic [ADDR_WIDTH-1:0]            bus_addr_o,
    output logic [DATA_WIDTH-1:0]            bus_data_o,
    output logic                             bus_read_o,
    output logic                             bus_write_o,
    output logic                             bus_valid_o,
    input  logic [DATA_WIDTH-1:0]            bus_data_i,
    input  logic                             bus_valid_i
);

    localparam int IW = idx_width(NUM_PORTS);
    localparam int CW = cnt_width(TIMEOUT_CYCLES);

    bus_state_e            state_q, state_d;
    logic [IW-1:0]         grant_q, grant_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  rd_q, rd_d;
    logic                  wr_q, wr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic [NUM_PORTS-1:0]  arb_grant;
    logic [IW-1:0]         arb_idx;

    w0rm_rr_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .IW        (IW)
    ) u_rr (
        .req_i   (req_valid),
        .last_i  (grant_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: if (|arb_grant) begin
                grant_d = arb_idx;
                addr_d  = req_addr[arb_idx*ADDR_WIDTH +: ADDR_WIDTH];
                wdata_d = req_data[arb_idx*DATA_WIDTH +: DATA_WIDTH];
                rd_d    = req_read[arb_idx];
                wr_d    = req_write[arb_idx];
                rdata_d = '0;
                // Ambiguous access type is answered with an error and never reaches the bus
                err_d   = req_read[arb_idx] == req_write[arb_idx];
                state_d = err_d ? ST_RESP : ST_ISSUE;
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: if (bus_valid_i) begin
                rdata_d = rd_q ? bus_data_i : '0;
                err_d   = 1'b0;
                state_d = ST_RESP;
            end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                rdata_d = '0;
                err_d   = 1'b1;
                state_d = ST_RESP;
            end else begin
                cnt_d   = cnt_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            grant_q <= IW'(NUM_PORTS - 1);
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign req_ready   = (reset && state_q == ST_IDLE) ? arb_grant : '0;
    assign resp_valid  = (state_q == ST_RESP) ? (NUM_PORTS'(1) << grant_q) : '0;
    assign resp_error  = (state_q == ST_RESP) && err_q;
    assign resp_data   = (state_q == ST_RESP) ? rdata_q : '0;
    assign bus_valid_o = state_q == ST_ISSUE;
    assign bus_addr_o  = addr_q;
    assign bus_data_o  = wdata_q;
    assign bus_read_o  = rd_q;
    assign bus_write_o = wr_q;

endmodule

// File: tb/tb_w0rm_core_bus_arbiter.sv
// tb_w0rm_core_bus_arbiter: directed scenarios plus randomized transactions against a
// round-robin / latency reference model, NUM_PORTS=4 and TIMEOUT_CYCLES=4.
module tb_w0rm_core_bus_arbiter;

    localparam int NP = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [NP-1:0]    req_valid = '0;
    logic [NP-1:0]    req_read = '0;
    logic [NP-1:0]    req_write = '0;
    logic [NP*AW-1:0] req_addr = '0;
    logic [NP*DW-1:0] req_data = '0;
    logic [NP-1:0]    req_ready;
    logic [NP-1:0]    resp_valid;
    logic             resp_error;
    logic [DW-1:0]    resp_data;
    logic [AW-1:0]    bus_addr_o;
    logic [DW-1:0]    bus_data_o;
    logic             bus_read_o;
    logic             bus_write_o;
    logic             bus_valid_o;
    logic [DW-1:0]    bus_data_i = '0;
    logic             bus_valid_i = 1'b0;

    int n_checks = 0;
    int n_fail = 0;
    int model_last = NP - 1;

    always #5 clk = ~clk;

    w0rm_core_bus_arbiter #(
        .NUM_PORTS      (NP),
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_read    (req_read),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .resp_valid  (resp_valid),
        .resp_error  (resp_error),
        .resp_data   (resp_data),
        .bus_addr_o  (bus_addr_o),
        .bus_data_o  (bus_data_o),
        .bus_read_o  (bus_read_o),
        .bus_write_o (bus_write_o),
        .bus_valid_o (bus_valid_o),
        .bus_data_i  (bus_data_i),
        .bus_valid_i (bus_valid_i)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Round-robin rule: first requester strictly after the last winner, wrapping
    function automatic int model_pick(input logic [NP-1:0] v);
        for (int i = 1; i <= NP; i++)
            if (v[(model_last + i) % NP]) return (model_last + i) % NP;
        return -1;
    endfunction

    function automatic logic [NP-1:0] onehot(input int p);
        logic [NP-1:0] v;
        v = '0;
        v[p] = 1'b1;
        return v;
    endfunction

    task automatic set_req(input int p, input logic rd, input logic wr,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[p] = 1'b1;
        req_read[p]  = rd;
        req_write[p] = wr;
        req_addr[p*AW +: AW] = a;
        req_data[p*DW +: DW] = d;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req_valid = '1;
        req_read = '1;
        bus_valid_i = 1'b1;
        tick();
        tick();
        n_checks++;
        if (req_ready !== '0) begin
            n_fail++;
            $display("FAIL reset_ready: got %b required 0", req_ready);
        end
        n_checks++;
        if ({resp_valid, resp_error, resp_data, bus_valid_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_resp: got %b/%b/%h/%b required all 0", resp_valid, resp_error, resp_data, bus_valid_o);
        end
        n_checks++;
        if ({bus_addr_o, bus_data_o, bus_read_o, bus_write_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_bus: got %h/%h/%b/%b required all 0", bus_addr_o, bus_data_o, bus_read_o, bus_write_o);
        end
        req_valid = '0;
        req_read = '0;
        bus_valid_i = 1'b0;
        reset = 1'b1;
        model_last = NP - 1;
        tick();
    endtask

    task automatic test_read();
        int g;
        set_req(0, 1'b1, 1'b0, 32'h100, 32'h0);
        #1;
        g = model_pick(req_valid);
        n_checks++;
        if (req_ready !== onehot(g)) begin
            n_fail++;
            $display("FAIL read_ready: got %b required %b", req_ready, onehot(g));
        end
        model_last = g;
        tick();
        req_valid = '0;
        n_checks++;
        if ({bus_valid_o, bus_read_o, bus_write_o, bus_addr_o} !== {1'b1, 1'b1, 1'b0, 32'h100}) begin
            n_fail++;
            $display("FAIL read_issue: got v%b r%b w%b a%h required v1 r1 w0 a00000100", bus_valid_o, bus_read_o, bus_write_o, bus_addr_o);
        end
        tick();
        n_checks++;
        if ({bus_valid_o, bus_addr_o} !== {1'b0, 32'h100}) begin
            n_fail++;
            $display("FAIL read_wait_hold: got v%b a%h required v0 a00000100", bus_valid_o, bus_addr_o);
        end
        tick();
        bus_valid_i = 1'b1;
        bus_data_i = 32'hDEADBEEF;
        n_checks++;
        if (resp_valid !== '0) begin
            n_fail++;
            $display("FAIL read_early_resp: got %b required 0", resp_valid);
        end
        tick();
        bus_valid_i = 1'b0;
        n_checks++;
        if ({resp_valid, resp_error, resp_data} !== {4'b0001, 1'b0, 32'hDEADBEEF}) begin
            n_fail++;
            $display("FAIL read_resp: got %b/%b/%h required 0001/0/deadbeef", resp_valid, resp_error, resp_data);
        end
        tick();
        n_checks++;
        if (resp_valid !== '0) begin
            n_fail++;
            $display("FAIL read_resp_pulse: got %b required 0", resp_valid);
        end
    endtask

    task automatic test_round_robin();
        int g;
        int port3_hits;
        logic [DW-1:0] d;
        port3_hits = 0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        model_last = NP - 1;
        for (int p = 0; p < 3; p++) set_req(p, 1'b1, 1'b0, AW'(32'h1000 + p * 16), '0);
        for (int k = 0; k < 6; k++) begin
            #1;
            g = model_pick(req_valid);
            n_checks++;
            if (req_ready !== onehot(g)) begin
                n_fail++;
                $display("FAIL rr_grant%0d: got %b required %b", k, req_ready, onehot(g));
            end
            if (req_ready[3]) port3_hits++;
            model_last = g;
            tick();
            n_checks++;
            if (bus_addr_o !== AW'(32'h1000 + g * 16)) begin
                n_fail++;
                $display("FAIL rr_addr%0d: got %h required %h", k, bus_addr_o, 32'h1000 + g * 16);
            end
            tick();
            d = $urandom;
            bus_valid_i = 1'b1;
            bus_data_i = d;
            tick();
            bus_valid_i = 1'b0;
            n_checks++;
            if ({resp_valid, resp_data} !== {onehot(g), d}) begin
                n_fail++;
                $display("FAIL rr_resp%0d: got %b/%h required %b/%h", k, resp_valid, resp_data, onehot(g), d);
            end
            tick();
        end
        n_checks++;
        if (port3_hits !== 0) begin
            n_fail++;
            $display("FAIL rr_port3: got %0d grants required 0", port3_hits);
        end
        req_valid = '0;
    endtask

    task automatic test_timeout();
        int g;
        int c;
        int issued_in_wait;
        logic [DW-1:0] d;
        d = $urandom;
        issued_in_wait = 0;
        set_req(2, 1'b0, 1'b1, 32'h2000, d);
        #1;
        g = model_pick(req_valid);
        n_checks++;
        if (req_ready !== onehot(g)) begin
            n_fail++;
            $display("FAIL to_ready: got %b required %b", req_ready, onehot(g));
        end
        model_last = g;
        tick();
        req_valid = '0;
        n_checks++;
        if ({bus_valid_o, bus_write_o, bus_read_o, bus_data_o} !== {1'b1, 1'b1, 1'b0, d}) begin
            n_fail++;
            $display("FAIL to_issue: got v%b w%b r%b d%h required v1 w1 r0 d%h", bus_valid_o, bus_write_o, bus_read_o, bus_data_o, d);
        end
        c = 0;
        while (c < 20) begin
            tick();
            c++;
            if (resp_valid !== '0) break;
            if (bus_valid_o) issued_in_wait++;
        end
        n_checks++;
        if (c !== 5) begin
            n_fail++;
            $display("FAIL to_latency: got %0d cycles required 5", c);
        end
        n_checks++;
        if ({resp_valid, resp_error, resp_data} !== {onehot(g), 1'b1, 32'h0}) begin
            n_fail++;
            $display("FAIL to_resp: got %b/%b/%h required %b/1/0", resp_valid, resp_error, resp_data, onehot(g));
        end
        n_checks++;
        if (issued_in_wait !== 0) begin
            n_fail++;
            $display("FAIL to_wait_valid: got %0d strobes required 0", issued_in_wait);
        end
        tick();
    endtask

    task automatic test_bad_type();
        int ports [2] = '{1, 0};
        logic bits [2] = '{1'b1, 1'b0};
        int g;
        for (int k = 0; k < 2; k++) begin
            set_req(ports[k], bits[k], bits[k], 32'h3000, 32'h55);
            #1;
            g = model_pick(req_valid);
            n_checks++;
            if (req_ready !== onehot(g)) begin
                n_fail++;
                $display("FAIL bad%0d_ready: got %b required %b", k, req_ready, onehot(g));
            end
            model_last = g;
            tick();
            req_valid = '0;
            n_checks++;
            if ({bus_valid_o, resp_valid, resp_error, resp_data} !== {1'b0, onehot(g), 1'b1, 32'h0}) begin
                n_fail++;
                $display("FAIL bad%0d_resp: got v%b %b/%b/%h required v0 %b/1/0", k, bus_valid_o, resp_valid, resp_error, resp_data, onehot(g));
            end
            tick();
            n_checks++;
            if ({bus_valid_o, resp_valid} !== '0) begin
                n_fail++;
                $display("FAIL bad%0d_after: got v%b %b required 0", k, bus_valid_o, resp_valid);
            end
        end
    endtask

    task automatic test_reset_mid();
        int g;
        set_req(3, 1'b1, 1'b0, 32'h4000, '0);
        #1;
        g = model_pick(req_valid);
        model_last = g;
        tick();
        req_valid = '0;
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        model_last = NP - 1;
        bus_valid_i = 1'b1;
        bus_data_i = $urandom;
        n_checks++;
        if ({resp_valid, resp_error, resp_data, bus_valid_o, bus_addr_o, bus_data_o, bus_read_o, bus_write_o} !== '0) begin
            n_fail++;
            $display("FAIL rmid_outputs: got %b/%b/%h/%b/%h/%h/%b/%b required all 0", resp_valid, resp_error, resp_data, bus_valid_o, bus_addr_o, bus_data_o, bus_read_o, bus_write_o);
        end
        tick();
        bus_valid_i = 1'b0;
        n_checks++;
        if ({resp_valid, bus_valid_o} !== '0) begin
            n_fail++;
            $display("FAIL rmid_stray: got %b/%b required 0", resp_valid, bus_valid_o);
        end
        req_valid = '1;
        req_read = '1;
        req_write = '0;
        #1;
        g = model_pick(req_valid);
        n_checks++;
        if (req_ready !== onehot(g)) begin
            n_fail++;
            $display("FAIL rmid_next_grant: got %b required %b", req_ready, onehot(g));
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_ignore();
        int g;
        bus_valid_i = 1'b1;
        bus_data_i = 32'hBAD0BAD0;
        tick();
        n_checks++;
        if ({resp_valid, bus_valid_o} !== '0) begin
            n_fail++;
            $display("FAIL ign_idle: got %b/%b required 0", resp_valid, bus_valid_o);
        end
        set_req(0, 1'b1, 1'b0, 32'h5000, '0);
        #1;
        g = model_pick(req_valid);
        n_checks++;
        if (req_ready !== onehot(g)) begin
            n_fail++;
            $display("FAIL ign_ready: got %b required %b", req_ready, onehot(g));
        end
        model_last = g;
        tick();
        req_valid = '0;
        n_checks++;
        if ({bus_valid_o, resp_valid} !== {1'b1, 4'b0000}) begin
            n_fail++;
            $display("FAIL ign_issue: got v%b %b required v1 0000", bus_valid_o, resp_valid);
        end
        tick();
        bus_valid_i = 1'b0;
        n_checks++;
        if ({bus_valid_o, resp_valid} !== '0) begin
            n_fail++;
            $display("FAIL ign_wait0: got v%b %b required 0", bus_valid_o, resp_valid);
        end
        tick();
        n_checks++;
        if (resp_valid !== '0) begin
            n_fail++;
            $display("FAIL ign_wait1: got %b required 0", resp_valid);
        end
        bus_valid_i = 1'b1;
        bus_data_i = 32'h0C0FFEE0;
        tick();
        bus_valid_i = 1'b0;
        n_checks++;
        if ({resp_valid, resp_error, resp_data} !== {onehot(g), 1'b0, 32'h0C0FFEE0}) begin
            n_fail++;
            $display("FAIL ign_resp: got %b/%b/%h required %b/0/0c0ffee0", resp_valid, resp_error, resp_data, onehot(g));
        end
        tick();
    endtask

    task automatic test_random();
        logic [NP-1:0] mask;
        logic [AW-1:0] a;
        logic [DW-1:0] d, bdata, exp_data;
        logic          rd, wr, bad, exp_err;
        int            g, dly, exp_c, c;
        for (int it = 0; it < 40; it++) begin
            mask = NP'($urandom);
            for (int p = 0; p < NP; p++) begin
                req_read[p] = 1'($urandom);
                req_write[p] = 1'($urandom);
                req_addr[p*AW +: AW] = $urandom;
                req_data[p*DW +: DW] = $urandom;
            end
            req_valid = mask;
            #1;
            g = model_pick(mask);
            if (g < 0) begin
                n_checks++;
                if (req_ready !== '0) begin
                    n_fail++;
                    $display("FAIL rnd%0d_idle_ready: got %b required 0", it, req_ready);
                end
                tick();
                n_checks++;
                if ({resp_valid, bus_valid_o} !== '0) begin
                    n_fail++;
                    $display("FAIL rnd%0d_idle: got %b/%b required 0", it, resp_valid, bus_valid_o);
                end
                continue;
            end
            n_checks++;
            if (req_ready !== onehot(g)) begin
                n_fail++;
                $display("FAIL rnd%0d_ready: got %b required %b", it, req_ready, onehot(g));
            end
            rd = req_read[g];
            wr = req_write[g];
            a = req_addr[g*AW +: AW];
            d = req_data[g*DW +: DW];
            bad = rd == wr;
            dly = $urandom_range(0, 5);
            bdata = $urandom;
            exp_c = bad ? 1 : (dly < TO ? 3 + dly : TO + 2);
            exp_err = bad || dly >= TO;
            exp_data = (exp_err || !rd) ? '0 : bdata;
            model_last = g;
            tick();
            if ($urandom_range(0, 1) == 1) req_valid = '0;
            c = 1;
            while (c <= exp_c) begin
                bus_valid_i = (c == 1) ? 1'($urandom) : (!bad && c == 2 + dly);
                bus_data_i = bus_valid_i ? bdata : DW'($urandom);
                n_checks++;
                if (bus_valid_o !== (c == 1 && !bad)) begin
                    n_fail++;
                    $display("FAIL rnd%0d_bus_valid c%0d: got %b required %b", it, c, bus_valid_o, c == 1 && !bad);
                end
                if (c == 1 && !bad) begin
                    n_checks++;
                    if ({bus_addr_o, bus_data_o, bus_read_o, bus_write_o} !== {a, d, rd, wr}) begin
                        n_fail++;
                        $display("FAIL rnd%0d_bus_fields: got %h/%h/%b/%b required %h/%h/%b/%b", it, bus_addr_o, bus_data_o, bus_read_o, bus_write_o, a, d, rd, wr);
                    end
                end
                n_checks++;
                if (resp_valid !== ((c == exp_c) ? onehot(g) : '0)) begin
                    n_fail++;
                    $display("FAIL rnd%0d_resp_valid c%0d: got %b required %b", it, c, resp_valid, (c == exp_c) ? onehot(g) : '0);
                end
                if (c == exp_c) begin
                    n_checks++;
                    if ({resp_error, resp_data} !== {exp_err, exp_data}) begin
                        n_fail++;
                        $display("FAIL rnd%0d_resp: got %b/%h required %b/%h", it, resp_error, resp_data, exp_err, exp_data);
                    end
                    break;
                end
                tick();
                c++;
            end
            bus_valid_i = 1'b0;
            req_valid = '0;
            tick();
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_read();
        test_round_robin();
        test_timeout();
        test_bad_type();
        test_reset_mid();
        test_ignore();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
